// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dpram_fifo_ctrl
// Description : Single-clock FIFO controller that sequences a dual-port SRAM
//               macro with a 1-cycle registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_fifo_ctrl #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int AFULL_LVL  = 1020,
    parameter int AEMPTY_LVL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW:0]   c_depth  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_one    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_ptr1   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_afull  = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0]   c_aempty = (AW+1)'(AEMPTY_LVL);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_pop_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_hold;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [AW:0]   w_count_nxt;

    // Acceptance is decided from start-of-cycle flags; nothing is accepted in a flush cycle.
    assign w_hold    = rst | clear;
    assign w_push_ok = push & ~r_full  & ~w_hold;
    assign w_pop_ok  = pop  & ~r_empty & ~w_hold;

    always_comb begin
        w_wptr_nxt  = w_push_ok ? r_wptr + c_ptr1 : r_wptr;
        w_rptr_nxt  = w_pop_ok  ? r_rptr + c_ptr1 : r_rptr;
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
        if (clear) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_depth);
            r_empty     <= (w_count_nxt == '0);
            r_afull     <= (w_count_nxt >= c_afull);
            r_aempty    <= (w_count_nxt <= c_aempty);
            r_pop_valid <= w_pop_ok;
            // Sticky error flags survive clear; only rst drops them.
            if (push && r_full && !clear) begin
                r_overflow <= 1'b1;
            end
            if (pop && r_empty && !clear) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign mem_wen      = w_push_ok;
    assign mem_waddr    = r_wptr;
    assign mem_wdata    = push_data;
    assign mem_ren      = w_pop_ok;
    assign mem_raddr    = r_rptr;

    assign pop_data     = mem_rdata;
    assign pop_valid    = r_pop_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_fifo_ctrl
// Description : Self-checking bench for dpram_fifo_ctrl with a queue-based
//               reference model and a behavioural SRAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AFL   = 1020;
    localparam int AEL   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_wen = 1'b0;
    logic          exp_ren = 1'b0;
    logic          obs_wen;
    logic          obs_ren;
    logic [AW-1:0] obs_waddr;

    dpram_fifo_ctrl #(
        .AW(AW), .DW(DW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro: write commits at the edge, read data registered one cycle later.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    function automatic logic [8:0] exp_status();
        int sz = q.size();
        return {sz == DEPTH, sz == 0, sz >= AFL, sz <= AEL,
                m_ovf, m_unf, exp_valid, exp_wen, exp_ren};
    endfunction

    function automatic logic [8:0] obs_status();
        return {full, empty, almost_full, almost_empty,
                overflow, underflow, pop_valid, obs_wen, obs_ren};
    endfunction

    // One clock cycle: drive inputs, sample combinational macro strobes, advance model.
    task automatic step(input logic rs, input logic cl, input logic ps,
                        input logic [DW-1:0] d, input logic pp);
        rst = rs; clear = cl; push = ps; push_data = d; pop = pp;
        exp_wen = ps && !rs && !cl && (q.size() < DEPTH);
        exp_ren = pp && !rs && !cl && (q.size() > 0);
        #2;
        obs_wen   = mem_wen;
        obs_ren   = mem_ren;
        obs_waddr = mem_waddr;
        @(posedge clk);
        if (rs) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!cl) begin
            if (ps && q.size() == DEPTH) m_ovf = 1'b1;
            if (pp && q.size() == 0)     m_unf = 1'b1;
        end
        exp_valid = exp_ren;
        if (exp_ren) exp_data = q.pop_front();
        if (exp_wen) q.push_back(d);
        if (rs || cl) q.delete();
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (count !== 11'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", count);
        end
        n_checks++;
        if ({empty, full, almost_empty, almost_full, pop_valid, obs_wen, obs_ren} !== 7'b1010000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 1010000",
                     {empty, full, almost_empty, almost_full, pop_valid, obs_wen, obs_ren});
        end
    endtask

    task automatic test_ordering();
        do_reset();
        for (int i = 1; i <= 8; i++) step(0, 0, 1, DW'(i), 0);
        n_checks++;
        if (count !== 11'd8) begin
            n_fail++; $display("FAIL order_count_full: got %0d want 8", count);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 1);
            n_checks++;
            if (!(pop_valid === 1'b1 && pop_data === DW'(k + 1) && count === 11'(7 - k))) begin
                n_fail++;
                $display("FAIL order_pop%0d: got valid=%b data=%h count=%0d want valid=1 data=%h count=%0d",
                         k, pop_valid, pop_data, count, DW'(k + 1), 7 - k);
            end
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if ({pop_valid, empty} !== 2'b01) begin
            n_fail++; $display("FAIL order_end: got valid=%b empty=%b want 0 1", pop_valid, empty);
        end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, DW'(i), 0);
            if (i >= AFL - 3) begin
                n_checks++;
                if (almost_full !== ((i + 1) >= AFL)) begin
                    n_fail++;
                    $display("FAIL fill_afull@%0d: got %b want %b", i + 1, almost_full, (i + 1) >= AFL);
                end
            end
        end
        n_checks++;
        if ({full, count} !== {1'b1, 11'd1024}) begin
            n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1 1024", full, count);
        end
        for (int k = 0; k < 512; k++) begin
            step(0, 0, 0, 0, 1);
            n_checks++;
            if (!(pop_valid === 1'b1 && pop_data === DW'(k))) begin
                n_fail++; $display("FAIL wrap_pop1_%0d: got %b/%h want 1/%h", k, pop_valid, pop_data, DW'(k));
            end
        end
        for (int k = 0; k < 512; k++) begin
            step(0, 0, 1, DW'(k), 0);
            if (k == 0) begin
                n_checks++;
                if (obs_waddr !== 10'd0) begin
                    n_fail++; $display("FAIL wrap_waddr: got %0d want 0", obs_waddr);
                end
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            step(0, 0, 0, 0, 1);
            n_checks++;
            if (!(pop_valid === 1'b1 && pop_data === DW'(j < 512 ? 512 + j : j - 512))) begin
                n_fail++;
                $display("FAIL wrap_drain_%0d: got %b/%h want 1/%h", j, pop_valid, pop_data,
                         DW'(j < 512 ? 512 + j : j - 512));
            end
        end
        n_checks++;
        if ({empty, count} !== {1'b1, 11'd0}) begin
            n_fail++; $display("FAIL wrap_end: got empty=%b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_full_collision();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, DW'(i + 1), 0);
        step(0, 0, 1, 32'hDEADBEEF, 1);
        n_checks++;
        if ({count, overflow, obs_wen, obs_ren} !== {11'd1023, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fullcol: got count=%0d ovf=%b wen=%b ren=%b want 1023 1 0 1",
                     count, overflow, obs_wen, obs_ren);
        end
        n_checks++;
        if (!(pop_valid === 1'b1 && pop_data === 32'd1)) begin
            n_fail++; $display("FAIL fullcol_data: got %b/%h want 1/00000001", pop_valid, pop_data);
        end
        for (int j = 0; j < DEPTH - 1; j++) begin
            step(0, 0, 0, 0, 1);
            n_checks++;
            if (!(pop_valid === 1'b1 && pop_data === DW'(j + 2))) begin
                n_fail++; $display("FAIL fullcol_drain_%0d: got %b/%h want 1/%h", j, pop_valid, pop_data, DW'(j + 2));
            end
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if ({empty, pop_valid, overflow} !== 3'b101) begin
            n_fail++; $display("FAIL fullcol_end: got %b want 101", {empty, pop_valid, overflow});
        end
    endtask

    task automatic test_empty_collision();
        do_reset();
        step(0, 0, 1, 32'hA5A5A5A5, 1);
        n_checks++;
        if ({count, underflow, pop_valid, obs_wen, obs_ren} !== {11'd1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL emptycol: got count=%0d unf=%b valid=%b wen=%b ren=%b want 1 1 0 1 0",
                     count, underflow, pop_valid, obs_wen, obs_ren);
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (!(pop_valid === 1'b1 && pop_data === 32'hA5A5A5A5 && count === 11'd0)) begin
            n_fail++; $display("FAIL emptycol_pop: got %b/%h/%0d want 1/a5a5a5a5/0", pop_valid, pop_data, count);
        end
    endtask

    // Runs after test_empty_collision so underflow is already set.
    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(32'h100 + i), 0);
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (!(pop_valid === 1'b1 && pop_data === 32'h100 && count === 11'd4)) begin
            n_fail++; $display("FAIL flush_pop: got %b/%h/%0d want 1/00000100/4", pop_valid, pop_data, count);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if ({pop_valid, count, empty, overflow, underflow} !== {1'b0, 11'd0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_state: got valid=%b count=%0d empty=%b ovf=%b unf=%b want 0 0 1 0 1",
                     pop_valid, count, empty, overflow, underflow);
        end
    endtask

    task automatic test_random();
        logic cl, rs, ps, pp;
        int   pbias;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pbias = ((c / 300) % 2 == 0) ? 70 : 35;
            rs = ($urandom_range(0, 599) == 0);
            cl = !rs && ($urandom_range(0, 199) == 0);
            ps = !cl && ($urandom_range(0, 99) < pbias);
            pp = !cl && ($urandom_range(0, 99) < 50);
            step(rs, cl, ps, $urandom, pp);
            n_checks++;
            if (obs_status() !== exp_status()) begin
                n_fail++; $display("FAIL rand_status@%0d: got %b want %b", c, obs_status(), exp_status());
            end
            n_checks++;
            if (count !== 11'(q.size())) begin
                n_fail++; $display("FAIL rand_count@%0d: got %0d want %0d", c, count, q.size());
            end
            if (exp_valid) begin
                n_checks++;
                if (pop_data !== exp_data) begin
                    n_fail++; $display("FAIL rand_data@%0d: got %h want %h", c, pop_data, exp_data);
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_ordering();
        test_fill_wrap();
        test_full_collision();
        test_empty_collision();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
